// File: rtl/alu_issue_stage.sv
// Instruction queue feeding an external combinational ALU, with a registered
// result stage and a count of results accepted downstream.
package alu_issue_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'h0,
    OP_SUB = 4'h1,
    OP_MUL = 4'h2,
    OP_SHL = 4'h3,
    OP_AND = 4'h4,
    OP_OR  = 4'h5,
    OP_XOR = 4'h6
  } opcode_t;

  typedef struct packed {
    opcode_t     opcode;
    logic [31:0] a;
    logic [31:0] b;
  } instruction_t;

endpackage

module alu_issue_stage
  import alu_issue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  instruction_t       in_iw,
  input  logic               in_valid,
  output logic               in_ready,
  output instruction_t       alu_iw,
  input  logic [31:0]        alu_result,
  output logic [31:0]        out_result,
  output opcode_t            out_opcode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CNT_W-1:0]   issued_cnt
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  instruction_t  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;

  logic full;
  logic empty;
  logic push;
  logic load_ok;
  logic issue;

  always_comb begin
    full     = (count == FULL_CNT);
    empty    = (count == '0);
    in_ready = !full;
    push     = in_valid && in_ready;
    load_ok  = !out_valid || out_ready;
    issue    = !empty && load_ok;
    alu_iw   = empty ? '0 : mem[rptr];
  end

  // Storage has no reset; the empty flag masks stale entries on alu_iw.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= in_iw;
  end

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push)  wptr <= wptr + AW'(1);
      if (issue) rptr <= rptr + AW'(1);
      case ({push, issue})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_opcode <= OP_ADD;
    end else if (issue) begin
      out_valid  <= 1'b1;
      out_result <= alu_result;
      out_opcode <= alu_iw.opcode;
    end else if (out_valid && out_ready) begin
      out_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      issued_cnt <= '0;
    end else if (out_valid && out_ready) begin
      issued_cnt <= issued_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a behavioural ALU on alu_iw.
module tb_alu_issue_stage;
  import alu_issue_pkg::*;

  logic         clk;
  logic         reset;
  instruction_t in_iw;
  logic         in_valid;
  logic         in_ready;
  instruction_t alu_iw;
  logic [31:0]  alu_result;
  logic [31:0]  out_result;
  opcode_t      out_opcode;
  logic         out_valid;
  logic         out_ready;
  logic [3:0]   issued_cnt;

  int checks;
  int failures;

  alu_issue_stage #(.DEPTH(4), .CNT_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_iw      (in_iw),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alu_iw     (alu_iw),
    .alu_result (alu_result),
    .out_result (out_result),
    .out_opcode (out_opcode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .issued_cnt (issued_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    case (alu_iw.opcode)
      OP_ADD:  alu_result = alu_iw.a + alu_iw.b;
      OP_SUB:  alu_result = alu_iw.a - alu_iw.b;
      OP_MUL:  alu_result = alu_iw.a * alu_iw.b;
      OP_SHL:  alu_result = alu_iw.a << alu_iw.b[4:0];
      default: alu_result = alu_iw.a ^ alu_iw.b;
    endcase
  end

  function automatic instruction_t mk(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    instruction_t w;
    w.opcode = opcode_t'(op);
    w.a      = a;
    w.b      = b;
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_iw = '0;
    #2;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid: got %0b want 0", out_valid); end
    checks++; if (out_result !== 32'd0) begin failures++; $display("FAIL rst_out_result: got %0h want 0", out_result); end
    checks++; if (out_opcode !== OP_ADD) begin failures++; $display("FAIL rst_out_opcode: got %0h want 0", out_opcode); end
    checks++; if (issued_cnt !== 4'd0) begin failures++; $display("FAIL rst_issued_cnt: got %0d want 0", issued_cnt); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready: got %0b want 1", in_ready); end
    checks++; if (alu_iw !== '0) begin failures++; $display("FAIL rst_alu_iw: got %0h want 0", alu_iw); end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_single_add();
    out_ready = 1'b1;
    in_iw = mk(OP_ADD, 32'd5, 32'd3); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL add_latency: got out_valid=%0b want 0 after edge 1", out_valid); end
    checks++; if (alu_iw.opcode !== OP_ADD || alu_iw.a !== 32'd5) begin failures++; $display("FAIL add_alu_iw: got %0h want head ADD 5,3", alu_iw); end
    tick();
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL add_valid: got %0b want 1", out_valid); end
    checks++; if (out_result !== 32'd8) begin failures++; $display("FAIL add_result: got %0d want 8", out_result); end
    checks++; if (out_opcode !== OP_ADD) begin failures++; $display("FAIL add_opcode: got %0h want 0", out_opcode); end
    checks++; if (issued_cnt !== 4'd0) begin failures++; $display("FAIL add_cnt_early: got %0d want 0", issued_cnt); end
    tick();
    checks++; if (issued_cnt !== 4'd1) begin failures++; $display("FAIL add_cnt: got %0d want 1", issued_cnt); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL add_valid_clear: got %0b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp [5];
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      exp[i] = 32'(i + 1) + 32'd100;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_in_ready_%0d: got %0b want 1", i, in_ready); end
      in_iw = mk(OP_ADD, 32'(i + 1), 32'd100); in_valid = 1'b1;
      tick();
    end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_full: got in_ready=%0b want 0", in_ready); end
    in_iw = mk(OP_ADD, 32'd99, 32'd99);
    tick();
    in_valid = 1'b0;
    checks++; if (out_result !== exp[0] || out_valid !== 1'b1) begin failures++; $display("FAIL bp_hold: got %0d/%0b want %0d/1", out_result, out_valid, exp[0]); end
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++; if (out_valid !== 1'b1 || out_result !== exp[i]) begin failures++; $display("FAIL bp_drain_%0d: got %0d/%0b want %0d/1", i, out_result, out_valid, exp[i]); end
      tick();
    end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_refused: got out_valid=%0b result=%0d want 0", out_valid, out_result); end
    checks++; if (issued_cnt !== 4'd6) begin failures++; $display("FAIL bp_cnt: got %0d want 6", issued_cnt); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    in_iw = mk(OP_SUB, 32'd7, 32'd5); in_valid = 1'b1;
    tick();
    in_iw = mk(OP_MUL, 32'd7, 32'd5);
    tick();
    checks++; if (out_valid !== 1'b1 || out_result !== 32'd2 || out_opcode !== OP_SUB) begin failures++; $display("FAIL b2b_sub: got %0d op %0h v %0b want 2 op 1", out_result, out_opcode, out_valid); end
    in_iw = mk(OP_SHL, 32'd7, 32'd5);
    tick();
    checks++; if (out_valid !== 1'b1 || out_result !== 32'd35 || out_opcode !== OP_MUL) begin failures++; $display("FAIL b2b_mul: got %0d op %0h v %0b want 35 op 2", out_result, out_opcode, out_valid); end
    in_iw = mk(4'hF, 32'd12, 32'd10);
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_result !== 32'd224 || out_opcode !== OP_SHL) begin failures++; $display("FAIL b2b_shl: got %0d op %0h v %0b want 224 op 3", out_result, out_opcode, out_valid); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_result !== 32'd6 || out_opcode !== opcode_t'(4'hF)) begin failures++; $display("FAIL b2b_unknown_op: got %0d op %0h v %0b want 6 op f", out_result, out_opcode, out_valid); end
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_end: got out_valid=%0b want 0", out_valid); end
    checks++; if (issued_cnt !== 4'd10) begin failures++; $display("FAIL b2b_cnt: got %0d want 10", issued_cnt); end
  endtask

  task automatic test_full_pop();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_iw = mk(OP_ADD, 32'(20 + i), 32'd0); in_valid = 1'b1;
      tick();
    end
    in_iw = mk(OP_ADD, 32'd50, 32'd0);
    out_ready = 1'b1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL fp_full: got in_ready=%0b want 0", in_ready); end
    tick();
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL fp_ready_after_pop: got %0b want 1", in_ready); end
    checks++; if (out_result !== 32'd21) begin failures++; $display("FAIL fp_w1: got %0d want 21", out_result); end
    tick();
    in_valid = 1'b0;
    checks++; if (out_result !== 32'd22) begin failures++; $display("FAIL fp_w2: got %0d want 22", out_result); end
    tick();
    checks++; if (out_result !== 32'd23) begin failures++; $display("FAIL fp_w3: got %0d want 23", out_result); end
    tick();
    checks++; if (out_result !== 32'd24) begin failures++; $display("FAIL fp_w4: got %0d want 24", out_result); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_result !== 32'd50) begin failures++; $display("FAIL fp_late_push: got %0d/%0b want 50/1", out_result, out_valid); end
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL fp_end: got out_valid=%0b want 0", out_valid); end
    checks++; if (issued_cnt !== 4'd0) begin failures++; $display("FAIL fp_cnt_wrap: got %0d want 0", issued_cnt); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_iw = mk(OP_ADD, 32'(40 + i), 32'd1); in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL ar_pre: got out_valid=%0b want 1", out_valid); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL ar_out_valid: got %0b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL ar_in_ready: got %0b want 1", in_ready); end
    checks++; if (alu_iw !== '0) begin failures++; $display("FAIL ar_alu_iw: got %0h want 0", alu_iw); end
    checks++; if (issued_cnt !== 4'd0 || out_result !== 32'd0) begin failures++; $display("FAIL ar_regs: got cnt %0d result %0d want 0 0", issued_cnt, out_result); end
    @(posedge clk); #1;
    reset = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL ar_stale_%0d: got out_valid=%0b result=%0d want 0", i, out_valid, out_result); end
    end
  endtask

  task automatic test_counter_wrap();
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      in_iw = mk(OP_OR, 32'(i), 32'd0); in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    checks++; if (issued_cnt !== 4'd15) begin failures++; $display("FAIL cw_pre_wrap: got %0d want 15", issued_cnt); end
    tick();
    tick();
    checks++; if (issued_cnt !== 4'd1) begin failures++; $display("FAIL cw_wrap: got %0d want 1", issued_cnt); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL cw_end: got out_valid=%0b want 0", out_valid); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_single_add();
    test_backpressure();
    test_back_to_back();
    test_full_pop();
    test_async_reset();
    test_counter_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
